uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller.sv | 145 ++++++++++++++
 tb/tb_uart_rx_controller.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receive controller: frames start/data/parity/stop bits using ticks from an
// external majority-vote sampler. Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_controller #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_data_in,
    input  logic [4:0]            prescale,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  sampled_bit,
    output logic                  sampler_enable,
    output logic [4:0]            edge_count,
    output logic [DATA_WIDTH-1:0] parallel_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [4:0]            presc_q;
    logic [3:0]            bit_count;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  stop_fault;
    logic                  bit_end;
    logic                  frame_start;
    logic                  stop_good;
    logic [2:0]            data_exit;

    assign bit_end     = (edge_count == presc_q - 5'd1);
    assign frame_start = ((state == IDLE) || (state == DONE)) && !serial_data_in;

`ifdef UART_RX_PARITY_EN
    logic par_en_q;
    logic par_type_q;
    logic par_fault;

    assign data_exit    = par_en_q ? PARITY : STOP;
    assign stop_good    = sampled_bit && !par_fault;
    assign parity_error = (state == DONE) && par_fault;
`else
    logic unused_parity_cfg;

    assign unused_parity_cfg = parity_enable ^ parity_type;
    assign data_exit         = STOP;
    assign stop_good         = sampled_bit;
    assign parity_error      = 1'b0;
`endif

    assign sampler_enable = (state == START) || (state == DATA) ||
`ifdef UART_RX_PARITY_EN
                            (state == PARITY) ||
`endif
                            (state == STOP);
    assign stop_error     = (state == DONE) && stop_fault;
    assign data_valid     = (state == DONE) && !stop_fault && !parity_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            edge_count    <= '0;
            bit_count     <= '0;
            shift_reg     <= '0;
            parallel_data <= '0;
            presc_q       <= '0;
            stop_fault    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q      <= 1'b0;
            par_type_q    <= 1'b0;
            par_fault     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    edge_count <= '0;
                    state      <= frame_start ? START : IDLE;
                end
                START: begin
                    edge_count <= bit_end ? '0 : edge_count + 5'd1;
                    if (bit_end) begin
                        state <= sampled_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    edge_count <= bit_end ? '0 : edge_count + 5'd1;
                    if (bit_end) begin
                        shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                        bit_count <= bit_count + 4'd1;
                        if (bit_count == LAST_BIT) begin
                            state <= data_exit;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    edge_count <= bit_end ? '0 : edge_count + 5'd1;
                    if (bit_end) begin
                        par_fault <= sampled_bit ^ (^shift_reg) ^ par_type_q;
                        state     <= STOP;
                    end
                end
`endif
                STOP: begin
                    edge_count <= bit_end ? '0 : edge_count + 5'd1;
                    if (bit_end) begin
                        // Word is loaded on DONE entry so it is visible alongside data_valid.
                        stop_fault <= !sampled_bit;
                        if (stop_good) begin
                            parallel_data <= shift_reg;
                        end
                        state <= DONE;
                    end
                end
                default: begin
                    edge_count <= '0;
                    state      <= IDLE;
                end
            endcase

            if (frame_start) begin
                presc_q    <= prescale;
                bit_count  <= '0;
                stop_fault <= 1'b0;
`ifdef UART_RX_PARITY_EN
                par_en_q   <= parity_enable;
                par_type_q <= parity_type;
                par_fault  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: drives serial frames tick by tick, models the external
// majority sampler, and checks outcomes against frame-level expectations.
module tb_uart_rx_controller;

    localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk            = 1'b0;
    logic          reset          = 1'b1;
    logic          serial_data_in = 1'b1;
    logic [4:0]    prescale       = 5'd8;
    logic          parity_enable  = 1'b0;
    logic          parity_type    = 1'b0;
    logic          sampled_bit;
    logic          sampler_enable;
    logic [4:0]    edge_count;
    logic [DW-1:0] parallel_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;

    int            checks      = 0;
    int            errors      = 0;
    int            cyc         = 0;
    int            cur_p       = 8;
    logic          s0          = 1'b1;
    logic          s1          = 1'b1;
    logic          s2          = 1'b1;
    logic [DW-1:0] dv_words[$];
    int            last_dv_cyc = 0;
    int            pe_cnt      = 0;
    int            se_cnt      = 0;
    logic [DW-1:0] exp_pd      = '0;

    uart_rx_controller #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (serial_data_in),
        .prescale       (prescale),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .sampled_bit    (sampled_bit),
        .sampler_enable (sampler_enable),
        .edge_count     (edge_count),
        .parallel_data  (parallel_data),
        .data_valid     (data_valid),
        .parity_error   (parity_error),
        .stop_error     (stop_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Three mid-bit samples, majority-voted, as the external data sampler would.
    always @(posedge clk) begin
        if (sampler_enable) begin
            if (int'(edge_count) == cur_p / 2 - 1) s0 <= serial_data_in;
            if (int'(edge_count) == cur_p / 2)     s1 <= serial_data_in;
            if (int'(edge_count) == cur_p / 2 + 1) s2 <= serial_data_in;
        end
    end
    assign sampled_bit = (s0 & s1) | (s0 & s2) | (s1 & s2);

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_words.push_back(parallel_data);
            last_dv_cyc = cyc;
        end
        if (parity_error === 1'b1) pe_cnt = pe_cnt + 1;
        if (stop_error === 1'b1)   se_cnt = se_cnt + 1;
    end

    task automatic idle_ticks(input int n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1 serial_data_in = 1'b1;
        end
    endtask

    // Drives one frame; det is the cycle index of the edge that first sees the start bit.
    task automatic send_frame(input logic [DW-1:0] d, input int p, input bit pen, input bit ptype,
                              input bit flip, input bit stop_bit, input bit chk, input bit chg,
                              input int cut, output int det, output int nbits);
        logic bits[$];
        int   tick;
        bits.push_back(1'b0);
        for (int unsigned i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pen && PAR_BUILT) bits.push_back((^d) ^ ptype ^ flip);
        bits.push_back(stop_bit);
        nbits         = bits.size();
        cur_p         = p;
        prescale      = 5'(p);
        parity_enable = pen;
        parity_type   = ptype;
        det           = 0;
        tick          = 0;
        for (int unsigned b = 0; b < nbits; b++) begin
            for (int unsigned k = 0; k < p; k++) begin
                if (cut != 0 && tick == cut) return;
                @(posedge clk);
                #1 serial_data_in = bits[b];
                if (tick == 0) det = cyc + 1;
                if (tick == 1 && chk) begin
                    checks++;
                    if (sampler_enable !== 1'b1 || edge_count !== 5'd0) begin
                        errors++;
                        $display("FAIL start_entry got en=%b ec=%0d want en=1 ec=0", sampler_enable, edge_count);
                    end
                end
                if (tick == 1 && chg) begin
                    prescale      = (p == 8) ? 5'd16 : 5'd8;
                    parity_enable = ~pen;
                    parity_type   = ~ptype;
                end
                tick++;
            end
        end
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        serial_data_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (edge_count !== 5'd0) begin
            errors++; $display("FAIL reset_edge_count got %0d want 0", edge_count);
        end
        checks++;
        if (sampler_enable !== 1'b0) begin
            errors++; $display("FAIL reset_sampler_enable got %b want 0", sampler_enable);
        end
        checks++;
        if ({data_valid, parity_error, stop_error} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses got %b want 000", {data_valid, parity_error, stop_error});
        end
        checks++;
        if (parallel_data !== '0) begin
            errors++; $display("FAIL reset_parallel_data got %h want 00", parallel_data);
        end
        reset = 1'b0;
        idle_ticks(4);
    endtask

    task automatic test_basic;
        int det, nbits, dv0, pe0, se0;
        dv0 = dv_words.size(); pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, det, nbits);
        idle_ticks(28);
        exp_pd = 8'h5A;
        checks++;
        if (dv_words.size() - dv0 !== 1) begin
            errors++; $display("FAIL basic_dv_count got %0d want 1", dv_words.size() - dv0);
        end
        checks++;
        if (parallel_data !== exp_pd) begin
            errors++; $display("FAIL basic_data got %h want %h", parallel_data, exp_pd);
        end
        checks++;
        if (last_dv_cyc !== det + 80) begin
            errors++; $display("FAIL basic_latency got %0d want %0d", last_dv_cyc - det, 80);
        end
        checks++;
        if (pe_cnt - pe0 !== 0 || se_cnt - se0 !== 0) begin
            errors++; $display("FAIL basic_errors got pe=%0d se=%0d want 0 0", pe_cnt - pe0, se_cnt - se0);
        end
    endtask

    task automatic test_parity;
        int det, nbits, dv0, pe0;
        dv0 = dv_words.size(); pe0 = pe_cnt;
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, det, nbits);
        idle_ticks(52);
        exp_pd = 8'hA5;
        checks++;
        if (dv_words.size() - dv0 !== 1 || parallel_data !== exp_pd) begin
            errors++; $display("FAIL parity_good got dv=%0d data=%h want dv=1 data=%h", dv_words.size() - dv0, parallel_data, exp_pd);
        end
        checks++;
        if (last_dv_cyc !== det + 16 * (PAR_BUILT ? 11 : 10)) begin
            errors++; $display("FAIL parity_latency got %0d want %0d", last_dv_cyc - det, 16 * (PAR_BUILT ? 11 : 10));
        end
        dv0 = dv_words.size(); pe0 = pe_cnt;
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, det, nbits);
        idle_ticks(52);
        checks++;
        if (pe_cnt - pe0 !== (PAR_BUILT ? 1 : 0)) begin
            errors++; $display("FAIL parity_bad_pe got %0d want %0d", pe_cnt - pe0, PAR_BUILT ? 1 : 0);
        end
        checks++;
        if (dv_words.size() - dv0 !== (PAR_BUILT ? 0 : 1) || parallel_data !== exp_pd) begin
            errors++; $display("FAIL parity_bad_hold got dv=%0d data=%h want dv=%0d data=%h", dv_words.size() - dv0, parallel_data, PAR_BUILT ? 0 : 1, exp_pd);
        end
    endtask

    task automatic test_glitch;
        int dv0, pe0, se0;
        dv0 = dv_words.size(); pe0 = pe_cnt; se0 = se_cnt;
        cur_p    = 8;
        prescale = 5'd8;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 serial_data_in = 1'b0;
        end
        idle_ticks(10);
        checks++;
        if (sampler_enable !== 1'b0 || edge_count !== 5'd0) begin
            errors++; $display("FAIL glitch_idle got en=%b ec=%0d want en=0 ec=0", sampler_enable, edge_count);
        end
        idle_ticks(100);
        checks++;
        if (dv_words.size() - dv0 !== 0 || pe_cnt - pe0 !== 0 || se_cnt - se0 !== 0) begin
            errors++; $display("FAIL glitch_pulses got dv=%0d pe=%0d se=%0d want 0 0 0", dv_words.size() - dv0, pe_cnt - pe0, se_cnt - se0);
        end
    endtask

    task automatic test_stop_error;
        int det, nbits, dv0, se0;
        dv0 = dv_words.size(); se0 = se_cnt;
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, det, nbits);
        idle_ticks(28);
        checks++;
        if (se_cnt - se0 !== 1 || dv_words.size() - dv0 !== 0) begin
            errors++; $display("FAIL stop_err got se=%0d dv=%0d want se=1 dv=0", se_cnt - se0, dv_words.size() - dv0);
        end
        checks++;
        if (parallel_data !== exp_pd) begin
            errors++; $display("FAIL stop_err_hold got %h want %h", parallel_data, exp_pd);
        end
        checks++;
        if (sampler_enable !== 1'b0 || edge_count !== 5'd0) begin
            errors++; $display("FAIL stop_err_idle got en=%b ec=%0d want en=0 ec=0", sampler_enable, edge_count);
        end
    endtask

    task automatic test_back_to_back;
        int det, nbits, dv0;
        dv0 = dv_words.size();
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, det, nbits);
        send_frame(8'hFE, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, det, nbits);
        idle_ticks(28);
        checks++;
        if (dv_words.size() - dv0 !== 2) begin
            errors++; $display("FAIL b2b_count got %0d want 2", dv_words.size() - dv0);
        end else begin
            checks++;
            if (dv_words[dv0] !== 8'h01 || dv_words[dv0+1] !== 8'hFE) begin
                errors++; $display("FAIL b2b_words got %h %h want 01 fe", dv_words[dv0], dv_words[dv0+1]);
            end
        end
        exp_pd = 8'hFE;
    endtask

    task automatic test_reset_mid_frame;
        int det, nbits, dv0, pe0, se0;
        dv0 = dv_words.size(); pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 44, det, nbits);
        @(posedge clk);
        #1 begin reset = 1'b1; serial_data_in = 1'b1; end
        @(posedge clk);
        #1 reset = 1'b0;
        exp_pd = '0;
        checks++;
        if (parallel_data !== exp_pd || sampler_enable !== 1'b0 || edge_count !== 5'd0) begin
            errors++; $display("FAIL reset_mid_state got data=%h en=%b ec=%0d want 00 0 0", parallel_data, sampler_enable, edge_count);
        end
        idle_ticks(20);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, det, nbits);
        idle_ticks(28);
        exp_pd = 8'h12;
        checks++;
        if (dv_words.size() - dv0 !== 1 || parallel_data !== exp_pd) begin
            errors++; $display("FAIL reset_mid_next got dv=%0d data=%h want dv=1 data=12", dv_words.size() - dv0, parallel_data);
        end
        checks++;
        if (pe_cnt - pe0 !== 0 || se_cnt - se0 !== 0) begin
            errors++; $display("FAIL reset_mid_errors got pe=%0d se=%0d want 0 0", pe_cnt - pe0, se_cnt - se0);
        end
    endtask

    task automatic test_random;
        int            det, nbits, dv0, pe0, se0, p;
        logic [DW-1:0] d;
        bit            pen, ptype, flip, stop_bit, chg, par_bad, good;
        for (int unsigned n = 0; n < 16; n++) begin
            d        = DW'($urandom);
            p        = ($urandom_range(0, 1) == 0) ? 8 : 16;
            pen      = 1'($urandom);
            ptype    = 1'($urandom);
            flip     = ($urandom_range(0, 3) == 0);
            stop_bit = ($urandom_range(0, 4) != 0);
            chg      = 1'($urandom);
            par_bad  = pen && PAR_BUILT && flip;
            good     = !par_bad && stop_bit;
            dv0 = dv_words.size(); pe0 = pe_cnt; se0 = se_cnt;
            send_frame(d, p, pen, ptype, flip, stop_bit, 1'b1, chg, 0, det, nbits);
            idle_ticks(3 * p + 4);
            if (good) exp_pd = d;
            checks++;
            if (dv_words.size() - dv0 !== (good ? 1 : 0)) begin
                errors++; $display("FAIL rand%0d_dv got %0d want %0d", n, dv_words.size() - dv0, good ? 1 : 0);
            end
            checks++;
            if (pe_cnt - pe0 !== (par_bad ? 1 : 0) || se_cnt - se0 !== (stop_bit ? 0 : 1)) begin
                errors++; $display("FAIL rand%0d_err got pe=%0d se=%0d want pe=%0d se=%0d", n, pe_cnt - pe0, se_cnt - se0, par_bad ? 1 : 0, stop_bit ? 0 : 1);
            end
            checks++;
            if (parallel_data !== exp_pd) begin
                errors++; $display("FAIL rand%0d_data got %h want %h", n, parallel_data, exp_pd);
            end
            if (good) begin
                checks++;
                if (last_dv_cyc !== det + nbits * p) begin
                    errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, last_dv_cyc - det, nbits * p);
                end
            end
            checks++;
            if (sampler_enable !== 1'b0 || edge_count !== 5'd0) begin
                errors++; $display("FAIL rand%0d_idle got en=%b ec=%0d want en=0 ec=0", n, sampler_enable, edge_count);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_glitch;
        test_stop_error;
        test_back_to_back;
        test_reset_mid_frame;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
